// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Round-robin arbiter that shares one memory (separate write and read command
// ports) between NREQ requesters. It issues registered memory commands, tags
// each outstanding read, and routes returning read data back with the
// requester ID.
// Build macro MEM_ARB_LOCK_EN adds the req_lock input and the MAX_LOCK
// parameter. A locked requester keeps the grant for up to MAX_LOCK
// consecutive cycles.

module mem_port_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned IDW    = 3
`ifdef MEM_ARB_LOCK_EN
  ,
  parameter int unsigned MAX_LOCK = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic                 mem_wren,
  output logic [AW-1:0]        mem_wr_addr,
  output logic [DW-1:0]        mem_wr_data,
  output logic                 mem_rden,
  output logic [AW-1:0]        mem_rd_addr,
  input  logic [DW-1:0]        mem_rd_data,
  input  logic                 mem_ovalid,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic                 err_orphan
);

  // One tag entry is {valid, requester id}.
  localparam int unsigned TW = IDW + 1;
  localparam logic [IDW-1:0] RR_RST = IDW'(NREQ - 1);

  logic [IDW-1:0]      rr_ptr;
  logic [IDW-1:0]      sh_c;
  logic [2*NREQ-1:0]   req_dbl_c;
  logic [NREQ-1:0]     rot_c;
  logic [IDW-1:0]      off_c;
  logic                any_c;
  logic [IDW-1:0]      win_c;
  logic [NREQ-1:0]     onehot_c;
  logic                win_we_c;
  logic [AW-1:0]       win_addr_c;
  logic [DW-1:0]       win_wdata_c;

  logic [IDW-1:0]      issue_id;
  logic [TW-1:0]       tag_in_c;
  logic [RD_LAT*TW-1:0] tag_pipe;
  logic                tag_out_v_c;
  logic [IDW-1:0]      tag_out_id_c;

`ifdef MEM_ARB_LOCK_EN
  localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

  logic                lock_hold;
  logic [IDW-1:0]      lock_id;
  logic [LCW-1:0]      lock_cnt;
  logic                lock_take_c;
  logic [LCW-1:0]      lock_cnt_nxt_c;
  logic                lock_hold_nxt_c;
`endif

  // Round-robin search starting just after the last winner; lock overrides it.
  always_comb begin
    sh_c      = IDW'((32'(rr_ptr) + 32'd1) % NREQ);
    req_dbl_c = {req, req};
    rot_c     = NREQ'(req_dbl_c >> sh_c);
    any_c     = 1'b0;
    off_c     = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!any_c && rot_c[j]) begin
        any_c = 1'b1;
        off_c = IDW'(j);
      end
    end
    win_c = IDW'((32'(sh_c) + 32'(off_c)) % NREQ);
`ifdef MEM_ARB_LOCK_EN
    lock_take_c = lock_hold && (|(req & (NREQ'(1) << lock_id)));
    if (lock_take_c) begin
      any_c = 1'b1;
      win_c = lock_id;
    end
`endif
    onehot_c = any_c ? (NREQ'(1) << win_c) : '0;
  end

  // Grant is combinational and held low while reset is asserted.
  always_comb begin
    gnt = rst ? '0 : onehot_c;
  end

  // Select the winning requester's command fields.
  always_comb begin
    win_we_c    = |(req_we & onehot_c);
    win_addr_c  = '0;
    win_wdata_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (onehot_c[i]) begin
        win_addr_c  = win_addr_c  | req_addr[i*AW +: AW];
        win_wdata_c = win_wdata_c | req_wdata[i*DW +: DW];
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // Consecutive-grant count for a locking requester.
  always_comb begin
    lock_cnt_nxt_c  = lock_take_c ? (lock_cnt + LCW'(1)) : LCW'(1);
    lock_hold_nxt_c = any_c && (|(req_lock & onehot_c)) &&
                      (lock_cnt_nxt_c < LCW'(MAX_LOCK));
  end

  // Lock state: owner, hold flag and grant count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_hold <= 1'b0;
      lock_id   <= '0;
      lock_cnt  <= '0;
    end else begin
      lock_hold <= lock_hold_nxt_c;
      lock_id   <= win_c;
      lock_cnt  <= lock_hold_nxt_c ? lock_cnt_nxt_c : '0;
    end
  end
`endif

  // Pointer update and registered memory command issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= RR_RST;
      mem_wren    <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rden    <= 1'b0;
      mem_rd_addr <= '0;
      issue_id    <= '0;
    end else begin
      mem_wren <= any_c && win_we_c;
      mem_rden <= any_c && !win_we_c;
      if (any_c) begin
        rr_ptr <= win_c;
      end
      if (any_c && win_we_c) begin
        mem_wr_addr <= win_addr_c;
        mem_wr_data <= win_wdata_c;
      end
      if (any_c && !win_we_c) begin
        mem_rd_addr <= win_addr_c;
        issue_id    <= win_c;
      end
    end
  end

  // Tag entry enters the pipe on the edge the memory samples the read command.
  always_comb begin
    tag_in_c     = {mem_rden, issue_id};
    tag_out_v_c  = tag_pipe[RD_LAT*TW-1];
    tag_out_id_c = tag_pipe[RD_LAT*TW-2 -: IDW];
  end

  if (RD_LAT == 1) begin : g_tag_lat1
    // Single-stage tag pipe.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_pipe <= '0;
      end else begin
        tag_pipe <= tag_in_c;
      end
    end
  end else begin : g_tag_latn
    // Multi-stage tag pipe, oldest entry in the top slot.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tag_pipe <= '0;
      end else begin
        tag_pipe <= {tag_pipe[(RD_LAT-1)*TW-1:0], tag_in_c};
      end
    end
  end

  // Match returning data to its tag; ovalid without a tag is a sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= mem_ovalid && tag_out_v_c;
      if (mem_ovalid && tag_out_v_c) begin
        rsp_id   <= tag_out_id_c;
        rsp_data <= mem_rd_data;
      end
      if (mem_ovalid && !tag_out_v_c) begin
        err_orphan <= 1'b1;
      end
    end
  end

endmodule
